// File: rtl/hazard_control_unit.sv
// Stall/flush control for the 5-stage RV32 pipeline: load-use, ID-resolved branch/jalr
// operand and cache-miss hazards, plus saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_branch,
  input  logic             ID_jal,
  input  logic             ID_jalr,
  input  logic             branch_taken,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_regwrite,
  input  logic             ID_EX_memread,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_memread,
  input  logic             ICACHE_stall,
  input  logic             DCACHE_stall,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t             state_q, state_d;
  logic               stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;

  logic       ctrl_use;
  logic       match_e, match_m;
  logic [1:0] need;
  logic       cache_stall;
  logic       flush_req;

  // Operand matches; jalr only ever reads rs1 so rs2 is masked off for it.
  always_comb begin
    ctrl_use = ID_branch | ID_jalr;
    match_e  = ((ID_EX_rd == ID_rs1) && ID_use_rs1 && (ID_EX_rd != 5'd0)) ||
               ((ID_EX_rd == ID_rs2) && ID_use_rs2 && !ID_jalr && (ID_EX_rd != 5'd0));
    match_m  = ((EX_MEM_rd == ID_rs1) && ID_use_rs1 && (EX_MEM_rd != 5'd0)) ||
               ((EX_MEM_rd == ID_rs2) && ID_use_rs2 && !ID_jalr && (EX_MEM_rd != 5'd0));
    need = 2'd0;
    if (ctrl_use && ID_EX_memread && match_e) begin
      need = 2'd2;
    end else if ((!ctrl_use && ID_EX_memread && match_e) ||
                 (ctrl_use && ID_EX_regwrite && !ID_EX_memread && match_e) ||
                 (ctrl_use && EX_MEM_memread && match_m)) begin
      need = 2'd1;
    end
    cache_stall = ICACHE_stall | DCACHE_stall;
    flush_req   = (ID_branch && branch_taken) || ID_jal || ID_jalr;
  end

  // Next-state, counters and pipeline enables; priority is reset > cache > data > flush.
  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    PC_write       = 1'b0;
    IF_ID_write    = 1'b0;
    IF_ID_flush    = 1'b0;
    ID_EX_write    = 1'b0;
    ID_EX_bubble   = 1'b0;
    EX_MEM_write   = 1'b0;
    MEM_WB_write   = 1'b0;

    if (rst) begin
      state_d        = RUN;
      stall_cnt_d    = 1'b0;
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else if (cache_stall) begin
      if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else if (((state_q == HOLD) && stall_cnt_q) || ((state_q == RUN) && (need != 2'd0))) begin
      ID_EX_write  = 1'b1;
      ID_EX_bubble = 1'b1;
      EX_MEM_write = 1'b1;
      MEM_WB_write = 1'b1;
      if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (state_q == HOLD) begin
        state_d     = RUN;
        stall_cnt_d = 1'b0;
      end else if (need == 2'd2) begin
        state_d     = HOLD;
        stall_cnt_d = 1'b1;
      end
    end else begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_write  = 1'b1;
      EX_MEM_write = 1'b1;
      MEM_WB_write = 1'b1;
      state_d      = RUN;
      stall_cnt_d  = 1'b0;
      if (flush_req) begin
        IF_ID_flush = 1'b1;
        if (flush_count_q != '1) flush_count_d = flush_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q        <= state_d;
    stall_cnt_q    <= stall_cnt_d;
    stall_cycles_q <= stall_cycles_d;
    flush_count_q  <= flush_count_d;
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (CNT_W=4 so saturation is reachable).
module tb_hazard_control_unit;

  localparam int unsigned CNT_W = 4;
  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_write}
  localparam logic [6:0] C_RUN   = 7'b1101011;
  localparam logic [6:0] C_FLUSH = 7'b1111011;
  localparam logic [6:0] C_STALL = 7'b0001111;
  localparam logic [6:0] C_OFF   = 7'b0000000;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_rs1, ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic ID_use_rs1, ID_use_rs2, ID_branch, ID_jal, ID_jalr, branch_taken;
  logic ID_EX_regwrite, ID_EX_memread, EX_MEM_memread, ICACHE_stall, DCACHE_stall;
  logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_write;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_branch(ID_branch), .ID_jal(ID_jal), .ID_jalr(ID_jalr), .branch_taken(branch_taken),
    .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memread(ID_EX_memread),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
    .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble),
    .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
    ID_branch = 1'b0; ID_jal = 1'b0; ID_jalr = 1'b0; branch_taken = 1'b0;
    ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
    EX_MEM_rd = 5'd0; EX_MEM_memread = 1'b0; ICACHE_stall = 1'b0; DCACHE_stall = 1'b0;
  endtask

  // Inputs are set at a negedge; check enables just after, then let one rising edge pass.
  task automatic tick(input string tag, input logic [6:0] exp);
    #1;
    check(tag, 32'({PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
                    EX_MEM_write, MEM_WB_write}), 32'(exp));
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag, input int sc, input int fc);
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(sc));
    check({tag, "_flush_count"},  32'(flush_count),  32'(fc));
  endtask

  task automatic set_beq_load(input logic taken);
    clear_inputs();
    ID_branch = 1'b1; branch_taken = taken; ID_rs1 = 5'd7; ID_use_rs1 = 1'b1;
    ID_rs2 = 5'd8; ID_use_rs2 = 1'b1;
    ID_EX_rd = 5'd7; ID_EX_regwrite = 1'b1; ID_EX_memread = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    tick("reset_ctrl", C_OFF);
    tick("reset_ctrl2", C_OFF);
    check_counters("reset", 0, 0);
    rst = 1'b0;

    // Load-use on rs2: one bubble, then the load has moved to MEM.
    ID_rs1 = 5'd1; ID_use_rs1 = 1'b1; ID_rs2 = 5'd5; ID_use_rs2 = 1'b1;
    ID_EX_rd = 5'd5; ID_EX_regwrite = 1'b1; ID_EX_memread = 1'b1;
    tick("loaduse_stall", C_STALL);
    ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
    EX_MEM_rd = 5'd5; EX_MEM_memread = 1'b1;
    tick("loaduse_release", C_RUN);
    check_counters("loaduse", 1, 0);

    // Load feeding a taken beq: RUN stall, HOLD stall, then flush.
    set_beq_load(1'b1);
    tick("beq_load_run", C_STALL);
    ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
    EX_MEM_rd = 5'd7; EX_MEM_memread = 1'b1;
    tick("beq_load_hold", C_STALL);
    EX_MEM_rd = 5'd0; EX_MEM_memread = 1'b0;
    tick("beq_taken_flush", C_FLUSH);
    clear_inputs();
    tick("after_flush", C_RUN);
    check_counters("beq_load", 3, 1);

    // x0 never stalls; ALU result to a non-branch is bypassed.
    ID_EX_rd = 5'd0; ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_rs1 = 5'd0; ID_use_rs1 = 1'b1;
    tick("x0_load_nostall", C_RUN);
    clear_inputs();
    ID_EX_rd = 5'd3; ID_EX_regwrite = 1'b1; ID_rs1 = 5'd3; ID_use_rs1 = 1'b1;
    tick("alu_bypass_nostall", C_RUN);
    // Same ALU producer into a branch compared in ID: one stall.
    ID_branch = 1'b1; ID_rs1 = 5'd2; ID_rs2 = 5'd3; ID_use_rs2 = 1'b1;
    tick("alu_to_branch_stall", C_STALL);
    clear_inputs();
    tick("alu_to_branch_done", C_RUN);
    // jalr ignores an rs2 match.
    ID_jalr = 1'b1; ID_rs1 = 5'd4; ID_use_rs1 = 1'b1; ID_rs2 = 5'd6; ID_use_rs2 = 1'b1;
    ID_EX_rd = 5'd6; ID_EX_regwrite = 1'b1;
    tick("jalr_rs2_ignored", C_FLUSH);
    clear_inputs();
    // Load in MEM feeding a branch: one stall.
    ID_branch = 1'b1; ID_rs1 = 5'd9; ID_use_rs1 = 1'b1; EX_MEM_rd = 5'd9; EX_MEM_memread = 1'b1;
    tick("mem_load_branch_stall", C_STALL);
    clear_inputs();
    tick("mem_load_branch_done", C_RUN);
    check_counters("bypass_group", 5, 2);

    // D-cache miss while in HOLD freezes everything, then HOLD finishes.
    set_beq_load(1'b0);
    tick("dcache_enter_hold", C_STALL);
    clear_inputs();
    DCACHE_stall = 1'b1;
    for (int i = 0; i < 4; i++) tick("dcache_frozen", C_OFF);
    DCACHE_stall = 1'b0;
    tick("dcache_hold_resume", C_STALL);
    tick("dcache_back_run", C_RUN);
    check_counters("dcache_hold", 11, 2);

    // jal flush is suppressed under an I-cache miss.
    ID_jal = 1'b1; ICACHE_stall = 1'b1;
    for (int i = 0; i < 3; i++) tick("icache_jal_frozen", C_OFF);
    ICACHE_stall = 1'b0;
    tick("icache_jal_flush", C_FLUSH);
    clear_inputs();
    check_counters("icache_jal", 14, 3);

    // Saturation at 15.
    ID_rs1 = 5'd5; ID_use_rs1 = 1'b1; ID_EX_rd = 5'd5; ID_EX_memread = 1'b1;
    for (int i = 0; i < 3; i++) tick("sat_stall", C_STALL);
    check_counters("saturate", 15, 3);

    // Reset mid-HOLD returns to RUN with counters cleared.
    set_beq_load(1'b0);
    tick("rst_enter_hold", C_STALL);
    clear_inputs();
    rst = 1'b1;
    DCACHE_stall = 1'b1;
    tick("rst_in_hold_cache", C_OFF);
    rst = 1'b0;
    DCACHE_stall = 1'b0;
    tick("rst_exit_run", C_RUN);
    check_counters("rst_hold", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush counterpart to the pipeline's operand-bypass logic in the 5-stage RV32 core.
- Detects hazards that bypassing cannot cover: load-use, branch/jalr operands resolved in ID, and I/D-cache misses.
- Drives pipeline-register write enables, bubble insertion and IF/ID flush.
- Sequences multi-cycle stalls with a small FSM and keeps saturating performance counters.

Parameters:
CNT_W, 32, width of the stall_cycles and flush_count performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ID_rs1  in  5  rs1 of instruction in ID
ID_rs2  in  5  rs2 of instruction in ID
ID_use_rs1  in  1  ID instruction reads rs1
ID_use_rs2  in  1  ID instruction reads rs2
ID_branch  in  1  ID holds conditional branch (compared in ID)
ID_jal  in  1  ID holds jal
ID_jalr  in  1  ID holds jalr (reads rs1 only)
branch_taken  in  1  ID comparator result, valid when ID_branch
ID_EX_rd  in  5  destination in EX
ID_EX_regwrite  in  1  EX instruction writes rd
ID_EX_memread  in  1  EX instruction is a load
EX_MEM_rd  in  5  destination in MEM
EX_MEM_memread  in  1  MEM instruction is a load
ICACHE_stall  in  1  I-cache miss in progress
DCACHE_stall  in  1  D-cache miss in progress
PC_write  out  1  PC update enable
IF_ID_write  out  1  IF/ID register enable
IF_ID_flush  out  1  zero IF/ID contents (squash fetched instruction)
ID_EX_write  out  1  ID/EX register enable
ID_EX_bubble  out  1  load NOP into ID/EX instead of ID contents
EX_MEM_write  out  1  EX/MEM register enable
MEM_WB_write  out  1  MEM/WB register enable
stall_cycles  out  CNT_W  count of cycles with any stall
flush_count  out  CNT_W  count of IF/ID flushes

Behaviour:
- States: RUN, HOLD. Internal stall_cnt is 1 bit.
- Reset (rst=1 at a clk edge): state<=RUN, stall_cnt<=0, stall_cycles<=0, flush_count<=0.
- Outputs are combinational from state and inputs. While rst=1: all write enables 0, bubble 0, flush 0.
- Match definitions, with x = rs1 or rs2:
  - matchE(x): ID_EX_rd==ID_x && ID_use_x && ID_EX_rd!=0.
  - matchM(x): the same test using EX_MEM_rd.
  - jalr uses rs1 only.
- Data hazard stall need n (evaluated in RUN only):
  - n=2: (branch or jalr) and ID_EX_memread and matchE.
  - n=1:
    - non-branch consumer with ID_EX_memread and matchE; or
    - (branch or jalr) with ID_EX_regwrite, !memread, and matchE; or
    - (branch or jalr) with EX_MEM_memread and matchM.
  - n=0 otherwise.
- Priority per cycle: DCACHE_stall or ICACHE_stall > data stall > control flush.
- Cache stall (either stall input high), any state:
  - PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write all 0; bubble 0; flush 0.
  - state and stall_cnt frozen.
  - stall_cycles increments.
- RUN, no cache stall, n>0:
  - PC_write=0, IF_ID_write=0, ID_EX_write=1, ID_EX_bubble=1, EX/MEM and MEM/WB writes 1.
  - stall_cycles increments.
  - If n=2, state<=HOLD; else remain in RUN.
- HOLD, no cache stall:
  - Same stall outputs as above; state<=RUN next cycle. Hazard detection is not evaluated in HOLD.
- RUN, no cache stall, n=0:
  - All writes 1, bubble 0.
  - IF_ID_flush=1 iff (ID_branch && branch_taken) || ID_jal || ID_jalr. When asserted, flush_count increments.
  - No flush while stalling. A taken branch stalled for operands flushes in its first non-stalled cycle.
- Counters saturate at all-ones and never wrap.
- Reset asserted in HOLD or during a cache stall returns to RUN with no residual stall.

Test Plan:
- lw x5 in EX (ID_EX_memread=1, rd=5); add in ID reads rs2=5 with use_rs2=1 -> exactly 1 cycle with PC_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_cycles=1.
- lw x7 in EX, beq in ID with rs1=7 -> 2 stall cycles (RUN then HOLD). Then taken, load now in WB -> IF_ID_flush=1 for 1 cycle; flush_count=1.
- ID_EX_rd=0 with memread=1 and ID_rs1=0 -> no stall; addi x3 in EX, add in ID reads x3 -> no stall (left to bypass).
- DCACHE_stall high for 4 cycles while in HOLD -> all write enables 0 for 4 cycles, state held; then 1 more HOLD stall cycle, then RUN; stall_cycles=+6 total over the sequence.
- jal in ID with ICACHE_stall=1 for 3 cycles -> flush suppressed, all writes 0 for 3 cycles; flush asserted on the 4th cycle.
- stall_cycles preset near all-ones (CNT_W=4, reach 15), continue stalling -> holds at 15. Assert rst mid-HOLD -> next cycle RUN, both counters 0.
